// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch: PC, in-order imem request tracking and
// a fetch queue feeding decode, with redirect flush and stale-response drop.
module fetch_queue_unit #(
  parameter int              XLEN     = 64,
  parameter int              INSN_W   = 32,
  parameter int              FQ_DEPTH = 4,
  parameter int              MAX_OUT  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc_F,
  input  logic [XLEN-1:0]   PCBranch_F,
  input  logic              EProc_F,
  input  logic [XLEN-1:0]   EVAddr_F,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              insn_valid_D,
  input  logic              insn_ready_D,
  output logic [INSN_W-1:0] insn_D,
  output logic [XLEN-1:0]   pc_D,
  output logic [XLEN-1:0]   NextPC_F
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  cnt_t              r_out;
  cnt_t              r_drop;
  cnt_t              r_cnt;
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [INSN_W-1:0] r_insn [FQ_DEPTH];
  logic [XLEN-1:0]   r_ipc  [FQ_DEPTH];

  logic              w_redir;
  logic [XLEN-1:0]   w_target;
  cnt_t              w_live;
  logic [CW:0]       w_fill;
  logic              w_room;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_head_v;
  cnt_t              w_rsp;

  assign w_redir  = EProc_F | PCSrc_F;
  assign w_target = EProc_F ? EVAddr_F : PCBranch_F;

  // Only responses that will actually be queued reserve a slot.
  assign w_live = r_out - r_drop;
  assign w_fill = {1'b0, r_cnt} + {1'b0, w_live};
  assign w_room = w_fill < (CW+1)'(FQ_DEPTH);

  assign imem_req_valid = !reset && !w_redir &&
                          (r_out < CW'(MAX_OUT)) && w_room;
  assign imem_req_addr  = r_pc;

  assign w_issue  = imem_req_valid && imem_req_ready;
  assign w_rsp    = cnt_t'(imem_rsp_valid);
  assign w_push   = imem_rsp_valid && (r_drop == '0) && !w_redir;
  assign w_head_v = (r_cnt != '0);
  assign w_pop    = w_head_v && insn_ready_D && !w_redir;

  assign insn_valid_D = w_head_v;
  assign insn_D   = w_head_v ? r_insn[r_rp] : '0;
  assign pc_D     = w_head_v ? r_ipc[r_rp] : '0;
  assign NextPC_F = w_head_v ? r_ipc[r_rp] + XLEN'(4) : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_insn[r_wp] <= imem_rsp_data;
      r_ipc[r_wp]  <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      r_out <= r_out + cnt_t'(w_issue) - w_rsp;
      if (w_redir) begin
        // Everything still in flight belongs to the old stream.
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
        r_drop   <= r_out - w_rsp;
        r_cnt    <= '0;
        r_wp     <= '0;
        r_rp     <= '0;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - cnt_t'(1);
        end
        if (w_push) begin
          r_wp     <= r_wp + AW'(1);
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
        end
        if (w_pop) begin
          r_rp <= r_rp + AW'(1);
        end
        r_cnt <= r_cnt + cnt_t'(w_push) - cnt_t'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a variable-latency
// in-order imem model.
module tb_fetch_queue_unit;

  localparam int          XLEN     = 64;
  localparam int          INSN_W   = 32;
  localparam int          FQ_DEPTH = 4;
  localparam int          MAX_OUT  = 4;
  localparam logic [63:0] RPC      = 64'h1000;

  logic              clk;
  logic              reset;
  logic              PCSrc_F;
  logic [XLEN-1:0]   PCBranch_F;
  logic              EProc_F;
  logic [XLEN-1:0]   EVAddr_F;
  logic              imem_req_valid;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INSN_W-1:0] imem_rsp_data;
  logic              insn_valid_D;
  logic              insn_ready_D;
  logic [INSN_W-1:0] insn_D;
  logic [XLEN-1:0]   pc_D;
  logic [XLEN-1:0]   NextPC_F;

  fetch_queue_unit #(
    .XLEN(XLEN), .INSN_W(INSN_W), .FQ_DEPTH(FQ_DEPTH),
    .MAX_OUT(MAX_OUT), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(reset),
    .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
    .EProc_F(EProc_F), .EVAddr_F(EVAddr_F),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .insn_valid_D(insn_valid_D), .insn_ready_D(insn_ready_D),
    .insn_D(insn_D), .pc_D(pc_D), .NextPC_F(NextPC_F)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [63:0] exp_pc;

  logic [63:0] pq_addr[$];
  int          pq_due[$];
  logic [63:0] iss_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  // imem: fixed latency, in order, shares reset with the fetch unit
  always @(negedge clk) begin
    if (reset) begin
      pq_addr.delete();
      pq_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      if (pq_due.size() > 0 && pq_due[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mk(pq_addr[0]);
        void'(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pq_addr.push_back(imem_req_addr);
        pq_due.push_back(cyc + lat);
        iss_log.push_back(imem_req_addr);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!reset && dut.r_cnt == 3'(FQ_DEPTH)) begin
      n_cmp++;
      if (dut.w_push && !dut.w_pop) begin
        n_err++;
        $display("FAIL push_full: push into full queue at cyc %0d", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    sample();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (insn_valid_D !== 1'b0) begin
      n_err++;
      $display("FAIL rst_insn_valid: got %b want 0", insn_valid_D);
    end
    n_cmp++;
    if (insn_D !== '0 || pc_D !== '0 || NextPC_F !== '0) begin
      n_err++;
      $display("FAIL rst_outputs: insn %h pc %h next %h want 0",
               insn_D, pc_D, NextPC_F);
    end
    n_cmp++;
    if (imem_req_addr !== RPC) begin
      n_err++;
      $display("FAIL rst_addr: got %h want %h", imem_req_addr, RPC);
    end
  endtask

  task automatic test_sequential();
    int got;
    lat = 1;
    insn_ready_D = 1'b1;
    iss_log.delete();
    do_reset();
    exp_pc = RPC;
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      sample();
      if (insn_valid_D) begin
        if (got == 0) begin
          n_cmp++;
          if (i != 2) begin
            n_err++;
            $display("FAIL seq_latency: got %0d want 2", i);
          end
        end
        n_cmp++;
        if (pc_D !== exp_pc) begin
          n_err++;
          $display("FAIL seq_pc: got %h want %h", pc_D, exp_pc);
        end
        n_cmp++;
        if (insn_D !== mk(exp_pc)) begin
          n_err++;
          $display("FAIL seq_insn: got %h want %h", insn_D, mk(exp_pc));
        end
        n_cmp++;
        if (NextPC_F !== exp_pc + 64'd4) begin
          n_err++;
          $display("FAIL seq_nextpc: got %h want %h", NextPC_F, exp_pc + 64'd4);
        end
        exp_pc += 64'd4;
        got++;
      end
      tick();
      if (got == 4) insn_ready_D = 1'b0;
    end
    n_cmp++;
    if (got != 4) begin
      n_err++;
      $display("FAIL seq_timeout: got %0d pops want 4", got);
    end
    n_cmp++;
    if (iss_log.size() < 3 || iss_log[0] !== RPC ||
        iss_log[1] !== RPC + 64'd4 || iss_log[2] !== RPC + 64'd8) begin
      n_err++;
      $display("FAIL seq_req_addrs: got %0d entries want 1000,1004,1008",
               iss_log.size());
    end
  endtask

  task automatic test_stall();
    int got;
    for (int i = 0; i < 20; i++) tick();
    sample();
    n_cmp++;
    if (imem_req_valid !== 1'b0 || pq_addr.size() != 0) begin
      n_err++;
      $display("FAIL stall_issue: req_valid %b inflight %0d want 0/0",
               imem_req_valid, pq_addr.size());
    end
    n_cmp++;
    if (insn_valid_D !== 1'b1 || pc_D !== exp_pc) begin
      n_err++;
      $display("FAIL stall_head: valid %b pc %h want 1/%h",
               insn_valid_D, pc_D, exp_pc);
    end
    tick();
    insn_ready_D = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && got < 6; i++) begin
      sample();
      if (insn_valid_D) begin
        n_cmp++;
        if (pc_D !== exp_pc || insn_D !== mk(exp_pc)) begin
          n_err++;
          $display("FAIL stall_resume: pc %h insn %h want %h/%h",
                   pc_D, insn_D, exp_pc, mk(exp_pc));
        end
        exp_pc += 64'd4;
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 6) begin
      n_err++;
      $display("FAIL stall_timeout: got %0d pops want 6", got);
    end
  endtask

  task automatic test_redirect();
    bit seen;
    lat = 3;
    insn_ready_D = 1'b0;
    do_reset();
    sample();
    tick();
    sample();
    tick();
    sample();
    tick();
    PCSrc_F = 1'b1;
    PCBranch_F = 64'h2000;
    sample();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_no_issue: got %b want 0", imem_req_valid);
    end
    n_cmp++;
    if (imem_rsp_valid !== 1'b1 || pq_addr.size() != 2) begin
      n_err++;
      $display("FAIL redir_inflight: rsp %b pending %0d want 1/2",
               imem_rsp_valid, pq_addr.size());
    end
    tick();
    PCSrc_F = 1'b0;
    insn_ready_D = 1'b1;
    sample();
    n_cmp++;
    if (imem_req_addr !== 64'h2000 || imem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL redir_addr: addr %h valid %b want 2000/1",
               imem_req_addr, imem_req_valid);
    end
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      sample();
      if (insn_valid_D) begin
        seen = 1;
        n_cmp++;
        if (pc_D !== 64'h2000 || insn_D !== mk(64'h2000)) begin
          n_err++;
          $display("FAIL redir_first: pc %h insn %h want 2000/%h",
                   pc_D, insn_D, mk(64'h2000));
        end
        n_cmp++;
        if (i != 3) begin
          n_err++;
          $display("FAIL redir_latency: got %0d want 3", i);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL redir_timeout: no instruction after redirect");
    end
  endtask

  task automatic test_priority();
    lat = 1;
    insn_ready_D = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    PCSrc_F = 1'b1;
    PCBranch_F = 64'h2000;
    EProc_F = 1'b1;
    EVAddr_F = 64'h80;
    sample();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL prio_no_issue: got %b want 0", imem_req_valid);
    end
    tick();
    PCSrc_F = 1'b0;
    EProc_F = 1'b0;
    sample();
    n_cmp++;
    if (imem_req_addr !== 64'h80 || imem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL prio_addr: addr %h valid %b want 80/1",
               imem_req_addr, imem_req_valid);
    end
    n_cmp++;
    if (insn_valid_D !== 1'b0) begin
      n_err++;
      $display("FAIL prio_flush: got %b want 0", insn_valid_D);
    end
    tick();
    tick();
    sample();
    n_cmp++;
    if (insn_valid_D !== 1'b1 || pc_D !== 64'h80 || insn_D !== mk(64'h80)) begin
      n_err++;
      $display("FAIL prio_first: valid %b pc %h insn %h want 1/80/%h",
               insn_valid_D, pc_D, insn_D, mk(64'h80));
    end
  endtask

  task automatic test_redirect_pop();
    lat = 1;
    insn_ready_D = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    PCSrc_F = 1'b1;
    PCBranch_F = 64'h3000;
    sample();
    n_cmp++;
    if (imem_rsp_valid !== 1'b1 || insn_valid_D !== 1'b1) begin
      n_err++;
      $display("FAIL rpop_setup: rsp %b head %b want 1/1",
               imem_rsp_valid, insn_valid_D);
    end
    tick();
    PCSrc_F = 1'b0;
    sample();
    n_cmp++;
    if (insn_valid_D !== 1'b0 || imem_req_addr !== 64'h3000) begin
      n_err++;
      $display("FAIL rpop_empty: valid %b addr %h want 0/3000",
               insn_valid_D, imem_req_addr);
    end
    tick();
    sample();
    n_cmp++;
    if (insn_valid_D !== 1'b0) begin
      n_err++;
      $display("FAIL rpop_stale: valid %b pc %h want 0", insn_valid_D, pc_D);
    end
    tick();
    sample();
    n_cmp++;
    if (insn_valid_D !== 1'b1 || pc_D !== 64'h3000) begin
      n_err++;
      $display("FAIL rpop_first: valid %b pc %h want 1/3000",
               insn_valid_D, pc_D);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    lat = 3;
    insn_ready_D = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    sample();
    n_cmp++;
    if (insn_valid_D !== 1'b1 || pc_D !== RPC) begin
      n_err++;
      $display("FAIL rmid_setup: valid %b pc %h want 1/%h",
               insn_valid_D, pc_D, RPC);
    end
    tick();
    reset = 1'b1;
    sample();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_req: got %b want 0", imem_req_valid);
    end
    tick();
    sample();
    n_cmp++;
    if (insn_valid_D !== 1'b0 || pc_D !== '0 || imem_req_addr !== RPC) begin
      n_err++;
      $display("FAIL rmid_clear: valid %b pc %h addr %h want 0/0/%h",
               insn_valid_D, pc_D, imem_req_addr, RPC);
    end
    lat = 1;
    insn_ready_D = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sample();
      if (insn_valid_D) begin
        seen = 1;
        n_cmp++;
        if (pc_D !== RPC || insn_D !== mk(RPC)) begin
          n_err++;
          $display("FAIL rmid_restart: pc %h insn %h want %h/%h",
                   pc_D, insn_D, RPC, mk(RPC));
        end
      end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rmid_timeout: no instruction after reset");
    end
  endtask

  initial begin
    reset          = 1'b1;
    PCSrc_F        = 1'b0;
    PCBranch_F     = '0;
    EProc_F        = 1'b0;
    EVAddr_F       = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    insn_ready_D   = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_priority();
    test_redirect_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
